// File: rtl/imul_accum_reduce.sv
// imul_accum_reduce: sums a configured number of 32-bit multiplier products
// per job and returns one accumulated result with a sticky carry-out flag.
module imul_accum_reduce #(
    parameter int ACC_NBITS = 40,
    parameter int LEN_NBITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_val,
    output logic                 cfg_rdy,
    input  logic [LEN_NBITS-1:0] cfg_msg,
    input  logic                 recv_val,
    output logic                 recv_rdy,
    input  logic [31:0]          recv_msg,
    output logic                 send_val,
    input  logic                 send_rdy,
    output logic [ACC_NBITS-1:0] send_msg,
    output logic                 send_ovf
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [ACC_NBITS-1:0]  acc_q;
    logic [ACC_NBITS-1:0]  acc_d;
    logic [LEN_NBITS-1:0]  cnt_q;
    logic [LEN_NBITS-1:0]  cnt_d;
    logic                  ovf_q;
    logic                  ovf_d;
    logic [ACC_NBITS:0]    sum;
    logic                  cfg_go;
    logic                  recv_go;
    logic                  send_go;

    // One extra bit on the adder captures the carry-out of the wrap.
    assign sum = {1'b0, acc_q} + (ACC_NBITS+1)'(recv_msg);

    assign cfg_go  = cfg_val  & cfg_rdy;
    assign recv_go = recv_val & recv_rdy;
    assign send_go = send_val & send_rdy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        cfg_rdy  = 1'b0;
        recv_rdy = 1'b0;
        send_val = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cfg_rdy = 1'b1;
                if (cfg_go) begin
                    acc_d = '0;
                    cnt_d = cfg_msg;
                    ovf_d = 1'b0;
                    if (cfg_msg == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ACCUM;
                    end
                end
            end
            S_ACCUM: begin
                recv_rdy = 1'b1;
                if (recv_go) begin
                    acc_d = sum[ACC_NBITS-1:0];
                    ovf_d = ovf_q | sum[ACC_NBITS];
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == LEN_NBITS'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                send_val = 1'b1;
                if (send_go) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Gate data with valid so downstream never sees stale sums as data.
    assign send_msg = acc_q & {ACC_NBITS{send_val}};
    assign send_ovf = ovf_q & send_val;

`ifndef SYNTHESIS
    function automatic string line_trace();
        string st;
        unique case (state_q)
            S_IDLE:  st = "I";
            S_ACCUM: st = "A";
            S_DONE:  st = "D";
            default: st = "?";
        endcase
        return $sformatf("%b%b:%h|%b%b:%h|%s|%b%b:%h:%b",
                         cfg_val, cfg_rdy, cfg_msg,
                         recv_val, recv_rdy, recv_msg, st,
                         send_val, send_rdy, send_msg, send_ovf);
    endfunction
`endif

endmodule

// File: tb/tb_imul_accum_reduce.sv
// Directed and randomized checks of imul_accum_reduce against
// a plain-arithmetic job-sum model.
module tb_imul_accum_reduce;

    localparam int ACC = 40;
    localparam int LEN = 16;

    logic           clk;
    logic           reset;
    logic           cfg_val;
    logic           cfg_rdy;
    logic [LEN-1:0] cfg_msg;
    logic           recv_val;
    logic           recv_rdy;
    logic [31:0]    recv_msg;
    logic           send_val;
    logic           send_rdy;
    logic [ACC-1:0] send_msg;
    logic           send_ovf;

    logic           c_cfg_val;
    logic           c_cfg_rdy;
    logic [LEN-1:0] c_cfg_msg;
    logic           c_recv_val;
    logic           c_recv_rdy;
    logic [31:0]    c_recv_msg;
    logic           c_send_val;
    logic           c_send_rdy;
    logic [31:0]    c_send_msg;
    logic           c_send_ovf;

    int errors = 0;
    int checks = 0;
    logic [31:0] prods[$];

    imul_accum_reduce #(.ACC_NBITS(ACC), .LEN_NBITS(LEN)) dut (
        .clk(clk), .reset(reset),
        .cfg_val(cfg_val), .cfg_rdy(cfg_rdy), .cfg_msg(cfg_msg),
        .recv_val(recv_val), .recv_rdy(recv_rdy), .recv_msg(recv_msg),
        .send_val(send_val), .send_rdy(send_rdy),
        .send_msg(send_msg), .send_ovf(send_ovf)
    );

    imul_accum_reduce #(.ACC_NBITS(32), .LEN_NBITS(LEN)) dut32 (
        .clk(clk), .reset(reset),
        .cfg_val(c_cfg_val), .cfg_rdy(c_cfg_rdy), .cfg_msg(c_cfg_msg),
        .recv_val(c_recv_val), .recv_rdy(c_recv_rdy), .recv_msg(c_recv_msg),
        .send_val(c_send_val), .send_rdy(c_send_rdy),
        .send_msg(c_send_msg), .send_ovf(c_send_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one job over the queued products and checks the result.
    task automatic run_job(input int max_gap, input int stall,
                           input bit chk_cyc);
        int n;
        int edges;
        int t;
        logic [63:0] total;
        logic [63:0] exp_sum;
        logic        exp_ovf;
        n = prods.size();
        edges = 0;
        total = 0;
        chk("idle_cfg_rdy", 64'(cfg_rdy), 64'd1);
        cfg_val = 1'b1;
        cfg_msg = n[LEN-1:0];
        tick();
        edges++;
        cfg_val = 1'b0;
        foreach (prods[i]) begin
            int gap;
            gap = $urandom_range(max_gap, 0);
            repeat (gap) begin
                tick();
                edges++;
            end
            recv_val = 1'b1;
            recv_msg = prods[i];
            t = 0;
            while (!recv_rdy && t < 50) begin
                tick();
                t++;
            end
            chk("recv_wait", 64'(t < 50), 64'd1);
            tick();
            edges++;
            recv_val = 1'b0;
            recv_msg = $urandom;
            total += 64'(prods[i]);
        end
        exp_sum = total % (64'd1 << ACC);
        exp_ovf = (total >= (64'd1 << ACC));
        chk("res_val", 64'(send_val), 64'd1);
        chk("res_msg", 64'(send_msg), exp_sum);
        chk("res_ovf", 64'(send_ovf), 64'(exp_ovf));
        chk("res_recv_rdy", 64'(recv_rdy), 64'd0);
        if (stall > 0) begin
            send_rdy = 1'b0;
            cfg_val  = 1'b1;
            cfg_msg  = 16'd7;
            recv_val = 1'b1;
            recv_msg = $urandom;
            repeat (stall) begin
                tick();
                edges++;
                chk("bp_val", 64'(send_val), 64'd1);
                chk("bp_msg", 64'(send_msg), exp_sum);
                chk("bp_recv_rdy", 64'(recv_rdy), 64'd0);
                chk("bp_cfg_rdy", 64'(cfg_rdy), 64'd0);
            end
            cfg_val  = 1'b0;
            recv_val = 1'b0;
            send_rdy = 1'b1;
        end
        tick();
        edges++;
        chk("post_val", 64'(send_val), 64'd0);
        chk("post_cfg_rdy", 64'(cfg_rdy), 64'd1);
        chk("post_msg", 64'(send_msg), 64'd0);
        if (chk_cyc) begin
            chk("job_cycles", 64'(edges), 64'(n + 2));
        end
    endtask

    initial begin
        reset      = 1'b0;
        cfg_val    = 1'b0;
        cfg_msg    = '0;
        recv_val   = 1'b0;
        recv_msg   = '0;
        send_rdy   = 1'b1;
        c_cfg_val  = 1'b0;
        c_cfg_msg  = '0;
        c_recv_val = 1'b0;
        c_recv_msg = '0;
        c_send_rdy = 1'b1;
        #12;
        chk("rst_cfg_rdy", 64'(cfg_rdy), 64'd1);
        chk("rst_recv_rdy", 64'(recv_rdy), 64'd0);
        chk("rst_send_val", 64'(send_val), 64'd0);
        chk("rst_send_msg", 64'(send_msg), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        prods = '{32'h2, 32'h5, 32'h7};
        run_job(0, 0, 1'b1);

        prods.delete();
        run_job(0, 0, 1'b1);

        prods = '{32'hFFFF_FFFF, 32'h2};
        run_job(0, 0, 1'b1);

        prods = '{32'h1, 32'h2, 32'h3, 32'h4};
        run_job(3, 5, 1'b0);

        // 32-bit accumulator wraps and flags the carry.
        c_cfg_val = 1'b1;
        c_cfg_msg = 16'd2;
        tick();
        c_cfg_val  = 1'b0;
        c_recv_val = 1'b1;
        c_recv_msg = 32'hFFFF_FFFF;
        tick();
        c_recv_msg = 32'h2;
        tick();
        c_recv_val = 1'b0;
        chk("w32_val", 64'(c_send_val), 64'd1);
        chk("w32_msg", 64'(c_send_msg), 64'h1);
        chk("w32_ovf", 64'(c_send_ovf), 64'd1);
        tick();
        chk("w32_idle", 64'(c_cfg_rdy), 64'd1);

        // Reset in the middle of a job, between clock edges.
        cfg_val = 1'b1;
        cfg_msg = 16'd5;
        tick();
        cfg_val  = 1'b0;
        recv_val = 1'b1;
        recv_msg = 32'd11;
        tick();
        recv_msg = 32'd12;
        tick();
        recv_val = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        chk("mid_rst_cfg_rdy", 64'(cfg_rdy), 64'd1);
        chk("mid_rst_recv_rdy", 64'(recv_rdy), 64'd0);
        chk("mid_rst_send_val", 64'(send_val), 64'd0);
        chk("mid_rst_send_msg", 64'(send_msg), 64'd0);
        chk("mid_rst_send_ovf", 64'(send_ovf), 64'd0);
        #2;
        reset = 1'b1;
        tick();
        prods = '{32'd9};
        run_job(0, 0, 1'b1);

        prods = '{32'd3, 32'd4};
        run_job(0, 0, 1'b1);
        prods = '{32'd10};
        run_job(0, 0, 1'b1);

        // 40-bit carry needs many large products.
        prods.delete();
        repeat (300) prods.push_back(32'hFFFF_FFFF);
        run_job(0, 0, 1'b1);

        for (int j = 0; j < 12; j++) begin
            int n;
            prods.delete();
            n = $urandom_range(8, 1);
            repeat (n) prods.push_back($urandom);
            run_job(2, $urandom_range(3, 0), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
